mean_broadcast_backward: RTL and testbench
==========================================

# mean_broadcast_backward

Backward-direction companion to the mean-reduction operator: accepts one reduced scalar (the upstream gradient of a mean over a dimension of length DIM_LEN), scales it by 1/DIM_LEN in Q16.16 fixed point, and emits DIM_LEN identical copies, one per element of the reduced dimension. It sits on the gradient path directly after the loss/upstream stage. It drives the element-wise stream that re-expands the reduced dimension.

## Interface
- DIM_LEN, 4, length of the reduced dimension; legal range 1..65535.
- RECIP_Q16, (65536 + DIM_LEN/2) / DIM_LEN, localparam; reciprocal of DIM_LEN in unsigned Q0.16, rounded to nearest; 18-bit signed when used.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- valid_in  input  1  input_data holds a scalar to accept.
- in_ready  output  1  block can accept a scalar this cycle.
- input_data  input  32  signed Q16.16 upstream scalar.
- valid_out  output  1  output_data holds a valid element.
- out_ready  input  1  downstream accepts output_data this cycle.
- output_data  output  32  signed Q16.16 scaled element.
- out_last  output  1  current output beat is element DIM_LEN-1.
- out_index  output  16  index (0..DIM_LEN-1) of the current output beat.

## Operation
- FSM states: IDLE, SCALE, EMIT.
- IDLE:
  - in_ready=1, valid_out=0.
  - On valid_in=1, capture input_data and go to SCALE.
- SCALE:
  - in_ready=0.
  - Compute the signed product input_data × RECIP_Q16 as 50-bit signed.
  - Register bits [47:16], an arithmetic shift right by 16 that truncates toward −∞, into the output register.
  - Clear the counter to 0 and go to EMIT.
- EMIT:
  - valid_out=1, output_data=scaled value, out_index=counter, out_last=(counter==DIM_LEN-1).
  - A beat transfers when valid_out && out_ready. On transfer, counter increments.
  - On transfer with out_last=1, go to IDLE.
  - With out_ready=0, all outputs stay frozen.
- Arithmetic: |RECIP_Q16| ≤ 65536, so the product cannot overflow 32 bits after the shift. No saturation logic.
- DIM_LEN=1: RECIP_Q16=65536, so output equals input. Exactly one beat, with out_last=1 and out_index=0.
- valid_in is ignored outside IDLE, because in_ready=0 there and no transfer occurs.
- Async reset mid-burst: state returns to IDLE immediately and the partial burst is abandoned. No beats are replayed after reset release.

## Timing
- Reset values:
  - in_ready=1 (IDLE).
  - valid_out=0.
  - output_data=0.
  - out_last=0.
  - out_index=0.
  - counter=0.
  - Captured scalar=0.
- Latency: scalar accepted on edge t; first valid_out=1 after edge t+1; last beat no earlier than edge t+DIM_LEN.
- Throughput: one beat per cycle while out_ready=1. The next scalar is accepted no earlier than the cycle after the last-beat transfer (in_ready rises after that edge).
- Minimum period per scalar: DIM_LEN+2 cycles.
- All outputs are registered; no combinational path from out_ready or valid_in to any output.
  - Exception: in_ready is a state decode, so it is also registered-equivalent.
- valid_out never drops without a transfer except on reset.

## Test plan
- DIM_LEN=4, input_data=0x00040000 (4.0), out_ready=1 → four beats of 0x00010000 on consecutive cycles; out_index 0,1,2,3; out_last only on index 3; first valid one cycle after SCALE.
- DIM_LEN=4, input_data=0xFFFF0000 (−1.0) → four beats of 0xFFFFC000 (−0.25).
- DIM_LEN=3, input_data=0x00030000 (3.0) → RECIP_Q16=21845, three beats of 0x0000FFFF (truncated); out_last on index 2.
- DIM_LEN=4, out_ready toggled 1,0,0,1,0,1,1 → exactly four transfers, output_data/out_index stable while stalled, in_ready=0 until after the final transfer; a valid_in pulse during EMIT is not accepted.
- DIM_LEN=1, input_data=0x12345678 → single beat 0x12345678 with out_last=1, out_index=0; back-to-back scalars give a 3-cycle repeat.
- Assert rst_n=0 during EMIT at index 2 → valid_out=0 and in_ready=1 asynchronously; after release, a new scalar produces a full burst starting at index 0.

Source files
------------

// File: rtl/mean_broadcast_backward.sv
// Gradient of a mean reduction: scales one upstream Q16.16 scalar by 1/DIM_LEN and
// re-expands it into DIM_LEN identical beats on a valid/ready stream.
module mean_broadcast_backward #(
    parameter int unsigned DIM_LEN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    output logic        in_ready,
    input  logic [31:0] input_data,
    output logic        valid_out,
    input  logic        out_ready,
    output logic [31:0] output_data,
    output logic        out_last,
    output logic [15:0] out_index
);

    localparam int unsigned RECIP_Q16 = (65536 + DIM_LEN / 2) / DIM_LEN;
    localparam logic [17:0] RECIP     = 18'(RECIP_Q16);
    localparam logic [15:0] LAST_IDX  = 16'(DIM_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCALE,
        EMIT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] scalar_q, scalar_d;
    logic [31:0] data_q, data_d;
    logic [15:0] count_q, count_d;

    logic signed [49:0] product;
    logic               at_last;
    logic               unused_product_bits;

    // Operands are widened to the full product width; RECIP is never negative.
    assign product = $signed({{18{scalar_q[31]}}, scalar_q}) * $signed({32'd0, RECIP});
    assign unused_product_bits = ^{product[49:48], product[15:0]};
    assign at_last = (count_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            scalar_q <= 32'd0;
            data_q   <= 32'd0;
            count_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            scalar_q <= scalar_d;
            data_q   <= data_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        scalar_d = scalar_q;
        data_d   = data_q;
        count_d  = count_q;
        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    scalar_d = input_data;
                    state_d  = SCALE;
                end
            end
            SCALE: begin
                // Bits [47:16] give an arithmetic shift that floors toward -inf.
                data_d  = product[47:16];
                count_d = 16'd0;
                state_d = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
                    if (at_last) begin
                        count_d = 16'd0;
                        state_d = IDLE;
                    end else begin
                        count_d = count_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state_q == IDLE);
        valid_out   = (state_q == EMIT);
        out_last    = (state_q == EMIT) && at_last;
        out_index   = count_q;
        output_data = data_q;
    end

endmodule

// File: tb/tb_mean_broadcast_backward.sv
// Bench for mean_broadcast_backward: three instances (DIM_LEN 4, 3, 1) checked by a
// beat scoreboard plus hand-written stall, back-to-back and mid-burst reset sequences.
module tb_mean_broadcast_backward;

    typedef struct {
        int          sel;
        logic [31:0] data;
        int          index;
        logic        last;
    } beat_t;

    typedef struct {
        int          sel;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        out_ready;
    logic [31:0] input_data;
    logic        vin  [3];
    logic        rdy  [3];
    logic        vo   [3];
    logic        last [3];
    logic [31:0] dout [3];
    logic [15:0] idx  [3];

    int    dims [3] = '{4, 3, 1};
    int    n_chk;
    int    n_fail;
    int    cyc;
    int    tx_cnt;
    beat_t q [$];

    logic        stall_v [3];
    logic [31:0] sd      [3];
    logic [15:0] si      [3];

    mean_broadcast_backward #(.DIM_LEN(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .valid_in(vin[0]), .in_ready(rdy[0]),
        .input_data(input_data), .valid_out(vo[0]), .out_ready(out_ready),
        .output_data(dout[0]), .out_last(last[0]), .out_index(idx[0])
    );
    mean_broadcast_backward #(.DIM_LEN(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .valid_in(vin[1]), .in_ready(rdy[1]),
        .input_data(input_data), .valid_out(vo[1]), .out_ready(out_ready),
        .output_data(dout[1]), .out_last(last[1]), .out_index(idx[1])
    );
    mean_broadcast_backward #(.DIM_LEN(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .valid_in(vin[2]), .in_ready(rdy[2]),
        .input_data(input_data), .valid_out(vo[2]), .out_ready(out_ready),
        .output_data(dout[2]), .out_last(last[2]), .out_index(idx[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every transfer seen before the next rising edge is popped and compared.
    always @(negedge clk) begin
        beat_t e;
        cyc++;
        for (int s = 0; s < 3; s++) begin
            if (!rst_n) begin
                stall_v[s] = 1'b0;
            end else begin
                if (stall_v[s]) begin
                    chk("stall_valid", 32'(vo[s]), 32'd1);
                    chk("stall_data", dout[s], sd[s]);
                    chk("stall_index", 32'(idx[s]), 32'(si[s]));
                end
                if (vo[s] && out_ready) begin
                    tx_cnt++;
                    if (q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_beat: inst %0d got %h expected none", s,
                                 dout[s]);
                    end else begin
                        e = q.pop_front();
                        chk("beat_inst", 32'(s), 32'(e.sel));
                        chk("beat_data", dout[s], e.data);
                        chk("beat_index", 32'(idx[s]), 32'(e.index));
                        chk("beat_last", 32'(last[s]), 32'(e.last));
                    end
                end
                stall_v[s] = vo[s] && !out_ready;
                sd[s]      = dout[s];
                si[s]      = idx[s];
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int sel, input logic [31:0] d, input logic [31:0] e,
                        output int acc_cyc);
        bit ok;
        ok         = 1'b0;
        input_data = d;
        vin[sel]   = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rdy[sel]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: inst %0d in_ready 0 expected 1", sel);
        end else begin
            for (int i = 0; i < dims[sel]; i++)
                q.push_back('{sel: sel, data: e, index: i, last: (i == dims[sel] - 1)});
        end
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        vin[sel] = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk(name, 32'(q.size()), 32'd0);
    endtask

    vec_t vecs [10];
    int   t0, t1, tx0;
    bit   seen;
    bit   pattern [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        cyc        = 0;
        tx_cnt     = 0;
        rst_n      = 1'b0;
        out_ready  = 1'b1;
        input_data = 32'd0;
        for (int s = 0; s < 3; s++) begin
            vin[s]     = 1'b0;
            stall_v[s] = 1'b0;
        end

        vecs[0] = '{sel: 0, din: 32'h0004_0000, exp: 32'h0001_0000};
        vecs[1] = '{sel: 0, din: 32'hFFFF_0000, exp: 32'hFFFF_C000};
        vecs[2] = '{sel: 0, din: 32'h0000_0001, exp: 32'h0000_0000};
        vecs[3] = '{sel: 0, din: 32'hFFFF_FFFF, exp: 32'hFFFF_FFFF};
        vecs[4] = '{sel: 0, din: 32'h7FFF_FFFF, exp: 32'h1FFF_FFFF};
        vecs[5] = '{sel: 1, din: 32'h0003_0000, exp: 32'h0000_FFFF};
        vecs[6] = '{sel: 1, din: 32'hFFFD_0000, exp: 32'hFFFF_0001};
        vecs[7] = '{sel: 1, din: 32'h0001_0000, exp: 32'h0000_5555};
        vecs[8] = '{sel: 2, din: 32'h1234_5678, exp: 32'h1234_5678};
        vecs[9] = '{sel: 2, din: 32'h8000_0000, exp: 32'h8000_0000};

        #12;
        for (int s = 0; s < 3; s++) begin
            chk("rst_in_ready", 32'(rdy[s]), 32'd1);
            chk("rst_valid_out", 32'(vo[s]), 32'd0);
            chk("rst_output_data", dout[s], 32'd0);
            chk("rst_out_last", 32'(last[s]), 32'd0);
            chk("rst_out_index", 32'(idx[s]), 32'd0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: SCALE cycle after accept, first beat valid one edge later.
        send(0, 32'h0004_0000, 32'h0001_0000, t0);
        chk("lat_scale_valid", 32'(vo[0]), 32'd0);
        chk("lat_scale_ready", 32'(rdy[0]), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_emit_valid", 32'(vo[0]), 32'd1);
        chk("lat_emit_index", 32'(idx[0]), 32'd0);
        chk("lat_emit_ready", 32'(rdy[0]), 32'd0);
        drain("lat_drain");

        foreach (vecs[i]) begin
            send(vecs[i].sel, vecs[i].din, vecs[i].exp, t0);
            drain("vec_drain");
        end

        // Stall pattern with a stray valid_in pulse while emitting.
        tx0 = tx_cnt;
        send(0, 32'h0008_0000, 32'h0002_0000, t0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            out_ready = pattern[i];
            vin[0]    = (i == 2);
            input_data = 32'hDEAD_BEEF;
            chk("stall_in_ready", 32'(rdy[0]), 32'd0);
            @(posedge clk);
            #1;
        end
        vin[0]    = 1'b0;
        out_ready = 1'b1;
        chk("stall_ready_after", 32'(rdy[0]), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("stall_transfers", 32'(tx_cnt - tx0), 32'd4);
        chk("stall_queue", 32'(q.size()), 32'd0);

        // DIM_LEN=1 back-to-back: one scalar every three cycles.
        send(2, 32'h1234_5678, 32'h1234_5678, t0);
        send(2, 32'h0001_0000, 32'h0001_0000, t1);
        chk("b2b_period", 32'(t1 - t0), 32'd3);
        drain("b2b_drain");

        // Asynchronous reset while index 2 is on the output.
        send(0, 32'h0004_0000, 32'h0001_0000, t0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (vo[0] && idx[0] == 16'd2) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_mid_reached", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(vo[0]), 32'd0);
        chk("rst_mid_ready", 32'(rdy[0]), 32'd1);
        chk("rst_mid_index", 32'(idx[0]), 32'd0);
        q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tx0 = tx_cnt;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_replay", 32'(tx_cnt - tx0), 32'd0);
        send(0, 32'hFFFF_0000, 32'hFFFF_C000, t0);
        drain("rst_after_drain");
        chk("rst_after_transfers", 32'(tx_cnt - tx0), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
